// File: rtl/uart_pkg.sv
`default_nettype none
// ---- uart_pkg : line-state encoding, option bit indices and defaults shared by UART TX/RX ----
// ---- rev 1.0 ----
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam int OPT_PAR_EN   = 7;
   localparam int OPT_PAR_ODD  = 6;
   localparam int OPT_TWO_STOP = 5;

   localparam int DEF_CLK_FREQ = 50000000;
   localparam int DEF_BAUD     = 9600;

   // Even parity is the XOR of the data bits; odd parity inverts it.
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ---- uart_baud_gen : bit-period counter, one-cycle tick on the last cycle of each bit ----
// ---- rev 1.0 ----
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic sys_clk,
   input  logic reset,
   input  logic enable,
   output logic bit_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge sys_clk) begin
      if (reset || !enable) begin
         r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bit_tick = enable && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ---- uart_tx : 8-bit UART transmitter, optional even/odd parity, 1 or 2 stop bits ----
// ---- rev 1.0 ----
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = DEF_CLK_FREQ,
   parameter int BAUD         = DEF_BAUD,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic [7:0] usr_options,
   input  logic [7:0] data_out_nios,
   input  logic       tx_start,
   output logic       serial_out,
   output logic       tx_busy,
   output logic       tx_done
);

   uart_state_t r_state;
   logic [7:0]  r_data;
   logic        r_par_en;
   logic        r_par_odd;
   logic        r_two_stop;
   logic [2:0]  r_bit_idx;
   logic        r_stop_idx;
   logic        r_serial;
   logic        r_busy;
   logic        r_done;

   logic        w_tick;
   logic        w_baud_en;
   logic        w_unused_opts;

   assign w_baud_en     = (r_state != IDLE);
   assign w_unused_opts = ^usr_options[4:0];

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .enable   (w_baud_en),
      .bit_tick (w_tick)
   );

   // Line level is driven from the same edge that changes state, so serial_out is glitch-free.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_data     <= '0;
         r_par_en   <= 1'b0;
         r_par_odd  <= 1'b0;
         r_two_stop <= 1'b0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_serial   <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_serial <= 1'b1;
               r_busy   <= 1'b0;
               if (tx_start) begin
                  r_data     <= data_out_nios;
                  r_par_en   <= usr_options[OPT_PAR_EN];
                  r_par_odd  <= usr_options[OPT_PAR_ODD];
                  r_two_stop <= usr_options[OPT_TWO_STOP];
                  r_state    <= START;
                  r_serial   <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            START: begin
               if (w_tick) begin
                  r_state   <= DATA;
                  r_bit_idx <= '0;
                  r_serial  <= r_data[0];
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_bit_idx == 3'd7) begin
                     r_bit_idx <= '0;
                     if (r_par_en) begin
                        r_state  <= PARITY;
                        r_serial <= parity_bit(r_data, r_par_odd);
                     end else begin
                        r_state    <= STOP;
                        r_stop_idx <= 1'b0;
                        r_serial   <= 1'b1;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_serial  <= r_data[r_bit_idx + 3'd1];
                  end
               end
            end
            PARITY: begin
               if (w_tick) begin
                  r_state    <= STOP;
                  r_stop_idx <= 1'b0;
                  r_serial   <= 1'b1;
               end
            end
            STOP: begin
               if (w_tick) begin
                  if (r_two_stop && !r_stop_idx) begin
                     r_stop_idx <= 1'b1;
                  end else begin
                     r_stop_idx <= 1'b0;
                     r_state    <= IDLE;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end
            end
            default: begin
               r_state  <= IDLE;
               r_serial <= 1'b1;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign serial_out = r_serial;
   assign tx_busy    = r_busy;
   assign tx_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ---- tb_uart_tx : directed scoreboard bench for uart_tx with CLKS_PER_BIT=16 ----
// ---- rev 1.0 ----
module tb_uart_tx;

   localparam int CPB = 16;

   logic       sys_clk = 1'b0;
   logic       reset;
   logic [7:0] usr_options;
   logic [7:0] data_out_nios;
   logic       tx_start;
   logic       serial_out;
   logic       tx_busy;
   logic       tx_done;

   typedef struct {
      logic [7:0] data;
      logic [7:0] opts;
      string      tag;
   } frame_t;

   frame_t sb[$];
   int vectors     = 0;
   int miscompares = 0;

   uart_tx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .sys_clk       (sys_clk),
      .reset         (reset),
      .usr_options   (usr_options),
      .data_out_nios (data_out_nios),
      .tx_start      (tx_start),
      .serial_out    (serial_out),
      .tx_busy       (tx_busy),
      .tx_done       (tx_done)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a request on a falling edge; return just after the accepting rising edge.
   task automatic send(input logic [7:0] d, input logic [7:0] opts, input string tag,
                       input bit hold, input bit score);
      @(negedge sys_clk);
      data_out_nios = d;
      usr_options   = opts;
      tx_start      = 1'b1;
      if (score) sb.push_back('{d, opts, tag});
      @(posedge sys_clk);
      #1;
      if (!hold) tx_start = 1'b0;
   endtask

   // Pops one expected frame and checks every cycle of it, then the tx_done cycle.
   task automatic check_frame(input bit perturb, input bit drop_start);
      frame_t f;
      logic   exp_bits[$];
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      f = sb.pop_front();
      exp_bits = {};
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(f.data[i]);
      if (f.opts[7]) exp_bits.push_back((^f.data) ^ f.opts[6]);
      exp_bits.push_back(1'b1);
      if (f.opts[5]) exp_bits.push_back(1'b1);
      for (int j = 0; j < exp_bits.size(); j++) begin
         for (int k = 0; k < CPB; k++) begin
            @(negedge sys_clk);
            chk($sformatf("%s_line_b%0d_c%0d", f.tag, j, k), serial_out, exp_bits[j]);
            chk($sformatf("%s_busy_b%0d", f.tag, j), tx_busy, 1'b1);
            chk($sformatf("%s_nodone_b%0d", f.tag, j), tx_done, 1'b0);
            if (drop_start && j == 0 && k == 0) tx_start = 1'b0;
            if (perturb && j == 3 && k == 5) begin
               tx_start      = 1'b1;
               data_out_nios = 8'h00;
               usr_options   = 8'h00;
            end
            if (perturb && j == 3 && k == 6) tx_start = 1'b0;
         end
      end
      @(negedge sys_clk);
      chk({f.tag, "_done"}, tx_done, 1'b1);
      chk({f.tag, "_done_busy"}, tx_busy, 1'b0);
      chk({f.tag, "_done_line"}, serial_out, 1'b1);
   endtask

   initial begin
      reset         = 1'b1;
      tx_start      = 1'b0;
      usr_options   = 8'h00;
      data_out_nios = 8'h00;
      repeat (3) @(negedge sys_clk);
      chk("rst_line", serial_out, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_done", tx_done, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         chk("idle_line", serial_out, 1'b1);
         chk("idle_busy", tx_busy, 1'b0);
         chk("idle_done", tx_done, 1'b0);
      end

      send(8'hA5, 8'h00, "a5_8n1", 1'b0, 1'b1);
      check_frame(1'b0, 1'b0);

      send(8'h03, 8'hC0, "03_odd", 1'b0, 1'b1);
      check_frame(1'b0, 1'b0);
      send(8'h03, 8'h80, "03_even", 1'b0, 1'b1);
      check_frame(1'b0, 1'b0);

      send(8'hFF, 8'hA0, "ff_even_2stop", 1'b0, 1'b1);
      check_frame(1'b1, 1'b0);

      // Continuous request: second frame accepted on the edge after tx_done.
      @(negedge sys_clk);
      data_out_nios = 8'h55;
      usr_options   = 8'h00;
      tx_start      = 1'b1;
      sb.push_back('{8'h55, 8'h00, "b2b_55"});
      sb.push_back('{8'h0F, 8'h00, "b2b_0f"});
      @(posedge sys_clk);
      #1;
      data_out_nios = 8'h0F;
      check_frame(1'b0, 1'b0);
      check_frame(1'b0, 1'b1);
      @(negedge sys_clk);
      chk("b2b_no_third", tx_busy, 1'b0);

      // Abort: reset lands on the 70th edge after acceptance, mid data bit 3 (line low).
      send(8'h00, 8'h00, "abort", 1'b0, 1'b0);
      repeat (69) @(negedge sys_clk);
      chk("abort_pre_line", serial_out, 1'b0);
      reset = 1'b1;
      @(negedge sys_clk);
      chk("abort_line", serial_out, 1'b1);
      chk("abort_busy", tx_busy, 1'b0);
      chk("abort_done", tx_done, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         chk("abort_idle_done", tx_done, 1'b0);
         chk("abort_idle_line", serial_out, 1'b1);
      end

      send(8'h96, 8'hC0, "post_rst", 1'b0, 1'b1);
      check_frame(1'b0, 1'b0);

      chk("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit half of the system UART; the counterpart of the existing receiver inside `uart`.
- Serialises one byte written by the Nios onto `serial_out`: 8N1/8E1/8O1, with 1 or 2 stop bits.
- Uses the same `usr_options` byte as the receiver, so both directions share one line format.
- Sits inside `uart` and drives the top-level `serial_out` pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208), sys_clk cycles per bit. Benches override it to 16.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- usr_options  input  8  line format. [7] parity enable. [6] parity odd=1/even=0. [5] two stop bits=1. [4:0] reserved, ignored.
- data_out_nios  input  8  byte to send; sampled when tx_start is accepted.
- tx_start  input  1  request to send a frame; level-sampled.
- serial_out  output  1  UART line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset values: serial_out=1, tx_busy=0, tx_done=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the frame. serial_out is 1 after that edge and no tx_done is issued.
- FSM states and line levels:
  - IDLE: serial_out=1.
  - START: serial_out=0.
  - DATA: serial_out = bit of data_out_nios, LSB first.
  - PARITY: serial_out = parity bit.
  - STOP: serial_out=1.
- Acceptance: in IDLE with tx_start=1 at edge N:
  - Latch data_out_nios and usr_options[7:5] into shadow registers.
  - Go to START.
  - From edge N onward: serial_out=0, tx_busy=1.
  - Later changes to the inputs do not affect the frame in flight.
- tx_start is ignored while not in IDLE. No queuing, no error flag.
- Bit timing:
  - A baud counter runs 0..CLKS_PER_BIT-1.
  - The state or bit advances when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
  - Every bit, including start, parity and stop, lasts exactly CLKS_PER_BIT cycles.
- DATA: a 3-bit index counts 0..7 and leaves DATA after bit 7 completes. Next state is PARITY if parity is enabled, otherwise STOP.
- Parity bit: even = XOR of the 8 latched bits; odd = its inverse.
- STOP: lasts 1 bit time, or 2 if the latched two-stop option is set.
- End of frame, on the edge that ends the last stop bit:
  - FSM goes to IDLE; tx_busy=0 and tx_done=1 for exactly that one cycle.
  - serial_out stays 1.
- Back-to-back: tx_start=1 during the tx_done cycle is accepted at the next edge, giving a minimum gap of 1 cycle of idle line.
- Frame length, start accept to tx_done: (1+8+P+S)*CLKS_PER_BIT cycles, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- No combinational path from any input to serial_out. serial_out is registered.

Decomposition:
- Package uart_pkg (shared with the receiver) holds:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Option bit indices: OPT_PAR_EN=7, OPT_PAR_ODD=6, OPT_TWO_STOP=5.
  - Default CLK_FREQ/BAUD constants.
- One sub-module, uart_baud_gen:
  - Parameterised by CLKS_PER_BIT.
  - Inputs: sys_clk, reset, and an enable that clears the count when low.
  - Output: a one-cycle bit_tick.
  - The receiver reuses it.

Test Plan (CLKS_PER_BIT=16):
- Reset then idle 100 cycles -> serial_out=1, tx_busy=0, tx_done never pulses.
- usr_options=8'h00, send 8'hA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. tx_done occurs 160 cycles after acceptance.
- usr_options=8'hC0 (odd parity), send 8'h03 -> parity bit=1. usr_options=8'h80 (even), same byte -> parity bit=0. Frame is 176 cycles.
- usr_options=8'hA0 (even parity, 2 stop bits), send 8'hFF -> parity=0, 2 stop bits, tx_done at 192 cycles. tx_start pulses mid-frame are ignored, and data_out_nios changes mid-frame do not alter the bits.
- Hold tx_start=1 continuously with 8'h55 then 8'h0F -> two complete frames separated by exactly one idle-high cycle, and tx_done pulses twice.
- Assert reset at cycle 70 of a frame -> serial_out=1 and tx_busy=0 on the next edge, no tx_done. A new frame after reset is bit-exact.
